// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode encodings, FSM state type and shift-amount width helper
//
// Purpose : definitions shared by universal_shift_reg and shift_ctrl.
// Contents: mode_e       - operation select encodings
//           state_e      - controller state (IDLE, RUN)
//           amt_width()  - shift-amount width able to represent WIDTH itself
//           is_shift()   - true for the five multi-step shift modes
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_NOP     = 3'b000,
    MODE_LOAD    = 3'b001,
    MODE_SHL     = 3'b010,
    MODE_SHR     = 3'b011,
    MODE_ROL     = 3'b100,
    MODE_ROR     = 3'b101,
    MODE_ASR     = 3'b110,
    MODE_NOP_ALT = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One extra bit beyond clog2 so that an amount equal to WIDTH fits.
  function automatic int amt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
           (mode == MODE_ROR) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - operation FSM and step counter for the universal shift register
//
// Purpose : accepts Start while idle, sequences Amt shift steps, generates Busy/Done.
// Ports   : clk       in  clock
//           rst       in  synchronous active-high reset
//           set       in  synchronous preset (aborts a run without Done)
//           hold      in  freezes FSM and counter
//           start     in  operation request (ignored while busy)
//           mode      in  [2:0] operation select
//           amt       in  [AW-1:0] number of shift steps
//           busy      out multi-step shift in progress
//           done      out one-cycle completion pulse
//           load_en   out parallel load this edge
//           step_en   out apply one shift step this edge
//           step_mode out [2:0] mode latched at start of the run
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          hold,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  output logic          busy,
  output logic          done,
  output logic          load_en,
  output logic          step_en,
  output logic [2:0]    step_mode
);

  state_e        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [2:0]    mode_q, mode_nxt;
  logic          done_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    load_en   = 1'b0;
    step_en   = 1'b0;
    if (!rst && !set && !hold) begin
      case (state)
        IDLE: begin
          if (start) begin
            if (mode == MODE_LOAD) begin
              load_en  = 1'b1;
              done_nxt = 1'b1;
            end else if (is_shift(mode) && (amt != '0)) begin
              mode_nxt  = mode;
              cnt_nxt   = amt;
              state_nxt = RUN;
            end else begin
              // NOP modes and zero-length shifts complete immediately
              done_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          step_en = 1'b1;
          cnt_nxt = cnt - 1'b1;
          if (cnt == AW'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Done is cleared at every edge unless a completion happens there, so
  // neither Hold nor Set can stretch an already-issued pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= MODE_NOP;
      done   <= 1'b0;
    end else if (set) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      done   <= done_nxt;
    end
  end

  assign busy      = (state == RUN);
  assign step_mode = mode_q;

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register with multi-step shift sequencing
//
// Purpose : WIDTH-bit register supporting load, logical/arithmetic shifts and rotates,
//           one bit per clock for Amt clocks.
// Ports   : Clk        in  clock
//           Rst        in  synchronous active-high reset (Q=0)
//           Set        in  synchronous active-high preset (Q=all ones)
//           Hold       in  freezes Q and controller
//           Start      in  operation request, sampled while Busy is low
//           Mode       in  [2:0] operation select (see shift_pkg::mode_e)
//           Amt        in  [AW-1:0] number of single-bit steps
//           I          in  [WIDTH-1:0] parallel load data
//           SinL, SinR in  serial fill bits for SHR / SHL, sampled live per step
//           Q          out [WIDTH-1:0] register contents
//           Busy, Done out status
//           SoutL      out Q[WIDTH-1]
//           SoutR      out Q[0]
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = amt_width(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Set,
  input  logic             Hold,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [AW-1:0]    Amt,
  input  logic [WIDTH-1:0] I,
  input  logic             SinL,
  input  logic             SinR,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             SoutL,
  output logic             SoutR
);

  logic             load_en;
  logic             step_en;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] q_nxt;

  shift_ctrl #(.AW(AW)) u_ctrl (
    .clk       (Clk),
    .rst       (Rst),
    .set       (Set),
    .hold      (Hold),
    .start     (Start),
    .mode      (Mode),
    .amt       (Amt),
    .busy      (Busy),
    .done      (Done),
    .load_en   (load_en),
    .step_en   (step_en),
    .step_mode (step_mode)
  );

  // load_en/step_en are already suppressed under Rst, Set and Hold.
  always_comb begin
    q_nxt = Q;
    if (load_en) begin
      q_nxt = I;
    end else if (step_en) begin
      case (step_mode)
        MODE_SHL: q_nxt = {Q[WIDTH-2:0], SinR};
        MODE_SHR: q_nxt = {SinL, Q[WIDTH-1:1]};
        MODE_ROL: q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
        MODE_ROR: q_nxt = {Q[0], Q[WIDTH-1:1]};
        MODE_ASR: q_nxt = {Q[WIDTH-1], Q[WIDTH-1:1]};
        default:  q_nxt = Q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Q <= '0;
    end else if (Set) begin
      Q <= '1;
    end else begin
      Q <= q_nxt;
    end
  end

  assign SoutL = Q[WIDTH-1];
  assign SoutR = Q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - randomized self-checking bench for universal_shift_reg
module tb_universal_shift_reg;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, set, hold, start, sinl, sinr;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  din;
  logic [W-1:0]  q;
  logic          busy, done, soutl, soutr;

  int vectors = 0;
  int miscompares = 0;
  int mq = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(W), .AW(AW)) dut (
    .Clk   (clk),
    .Rst   (rst),
    .Set   (set),
    .Hold  (hold),
    .Start (start),
    .Mode  (mode),
    .Amt   (amt),
    .I     (din),
    .SinL  (sinl),
    .SinR  (sinr),
    .Q     (q),
    .Busy  (busy),
    .Done  (done),
    .SoutL (soutl),
    .SoutR (soutr)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_shift_mode(input int m);
    return (m >= 2) && (m <= 6);
  endfunction

  // Whole-operation result computed arithmetically (fill bits constant per op).
  function automatic int model(input int m, input int n, input int qv, input int d,
                               input int sl, input int sr);
    int mask, k, sv;
    mask = (1 << W) - 1;
    k = n % W;
    case (m)
      1: return d & mask;
      2: return (n >= W) ? (sr ? mask : 0) : (((qv << n) | (sr ? (1 << n) - 1 : 0)) & mask);
      3: return (n >= W) ? (sl ? mask : 0)
                         : ((qv >> n) | (sl ? ((((1 << n) - 1) << (W - n)) & mask) : 0));
      4: return ((qv << k) | (qv >> (W - k))) & mask;
      5: return ((qv >> k) | (qv << (W - k))) & mask;
      6: begin
        sv = (qv >= (1 << (W - 1))) ? qv - (1 << W) : qv;
        return (sv >>> n) & mask;
      end
      default: return qv;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the post-Done cycle.
  task automatic run_op(input int m, input int n, input int d, input int sl, input int sr,
                        input int hold_mask, input bit junk);
    int expq, steps, remaining, it;
    expq  = model(m, n, mq, d, sl, sr);
    steps = is_shift_mode(m) ? n : 0;
    start = 1'b1; mode = 3'(m); amt = AW'(n); din = W'(d);
    sinl = 1'(sl); sinr = 1'(sr); hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    remaining = steps;
    it = 0;
    while (remaining > 0 && it < 64) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      hold = (it < 32) ? 1'((hold_mask >> it) & 1) : 1'b0;
      if (junk) begin
        start = 1'($urandom); mode = 3'($urandom); amt = AW'($urandom); din = W'($urandom);
      end
      if (!hold) remaining--;
      it++;
      @(negedge clk);
    end
    hold = 1'b0; start = 1'b0;
    check("busy_end", busy, 0);
    check("done_pulse", done, 1);
    check("q_final", q, expq);
    check("soutl", soutl, (expq >> (W - 1)) & 1);
    check("soutr", soutr, expq & 1);
    mq = expq;
    hold = 1'($urandom);
    @(negedge clk);
    check("done_once", done, 0);
    check("q_idle", q, mq);
    hold = 1'b0;
  endtask

  task automatic abort_run(input bit use_rst);
    start = 1'b1; mode = 3'(5); amt = AW'(6); din = '0; hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      check("abort_busy", busy, 1);
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1; else set = 1'b1;
    @(negedge clk);
    rst = 1'b0; set = 1'b0;
    check("abort_q", q, use_rst ? 8'h00 : 8'hFF);
    check("abort_busy_lo", busy, 0);
    check("abort_done", done, 0);
    mq = use_rst ? 0 : 'hFF;
    @(negedge clk);
    check("abort_no_done", done, 0);
    check("abort_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; set = 1'b0; hold = 1'b0; start = 1'b0;
    mode = '0; amt = '0; din = '0; sinl = 1'b0; sinr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    mq = 0;

    // directed cases
    run_op(1, 0, 'hA5, 0, 0, 0, 0);
    check("load_lit", q, 'hA5);
    run_op(4, 3, 0, 0, 0, 0, 1);
    check("rol3_lit", q, 'h2D);
    run_op(1, 0, 'h80, 0, 0, 0, 0);
    run_op(6, 2, 0, 0, 0, 0, 0);
    check("asr2_lit", q, 'hE0);
    run_op(1, 0, 'hA5, 0, 0, 0, 0);
    run_op(3, 8, 0, 0, 0, 0, 0);
    check("shr8_lit", q, 'h00);
    run_op(1, 0, 'hA5, 0, 0, 0, 0);
    run_op(2, 4, 0, 0, 1, 'b0110, 0);
    check("shl4_hold_lit", q, 'h5F);
    run_op(5, 11, 0, 0, 0, 0, 1);
    run_op(2, 0, 0, 0, 1, 0, 0);

    // Start with Hold high is ignored
    start = 1'b1; mode = 3'(1); din = 8'h3C; hold = 1'b1;
    @(negedge clk);
    start = 1'b0; hold = 1'b0;
    check("hold_start_q", q, mq);
    check("hold_start_done", done, 0);
    check("hold_start_busy", busy, 0);

    abort_run(1'b0);
    abort_run(1'b1);

    // start while busy with LOAD must be ignored
    run_op(1, 0, 'h96, 0, 0, 0, 0);
    start = 1'b1; mode = 3'(4); amt = AW'(3); hold = 1'b0;
    @(negedge clk);
    mode = 3'(1); din = 8'h3C;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("busy_load_ign", q, model(4, 3, 'h96, 0, 0, 0));
    check("busy_load_done", done, 1);
    mq = model(4, 3, 'h96, 0, 0, 0);
    @(negedge clk);

    // randomized operations
    for (int t = 0; t < 150; t++) begin
      int hm;
      hm = ($urandom_range(0, 3) == 0) ? int'($urandom) : 0;
      run_op($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 255),
             $urandom_range(0, 1), $urandom_range(0, 1), hm, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the register width in bits; legal for WIDTH >= 2.
REQ-002: Parameter AW, default $clog2(WIDTH)+1, SHALL set the shift-amount width so that the value WIDTH is representable.
REQ-003: Clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004: Rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005: Set  in  1  SHALL be a synchronous, active-high preset that forces every bit of Q to 1.
REQ-006: Hold  in  1  SHALL freeze Q and all internal state while high.
REQ-007: Start  in  1  SHALL request an operation; it is sampled only while Busy is low.
REQ-008: Mode  in  3  SHALL select the operation: 000 NOP; 001 LOAD; 010 SHL; 011 SHR; 100 ROL; 101 ROR; 110 ASR; 111 NOP.
REQ-009: Amt  in  AW  SHALL give the number of single-bit shift steps.
REQ-010: I  in  WIDTH  SHALL be the parallel load data.
REQ-011: SinL  in  1  SHALL be the serial bit entering the MSB on SHR.
REQ-012: SinR  in  1  SHALL be the serial bit entering the LSB on SHL.
REQ-013: Q  out  WIDTH  SHALL be the register contents.
REQ-014: Busy  out  1  SHALL indicate that a multi-step shift is in progress.
REQ-015: Done  out  1  SHALL be a one-cycle completion pulse.
REQ-016: SoutL  out  1  SHALL equal Q[WIDTH-1], combinationally.
REQ-017: SoutR  out  1  SHALL equal Q[0], combinationally.

Function
REQ-018: Per-edge priority SHALL be Rst > Set > Hold > Start/step.
REQ-019: Start accepted at edge E0 with Mode LOAD SHALL load Q<=I at E0 and set Done=1 for the following cycle; Busy stays 0.
REQ-020: Start at E0 with a NOP mode, or with a shift mode and Amt=0, SHALL leave Q unchanged and pulse Done after E0.
REQ-021: Start at E0 with a shift mode and Amt>0 SHALL latch Mode and Amt, set Busy=1, and enter state RUN.
REQ-022: In RUN, one step SHALL be applied at each non-held edge E1..E_Amt; at E_Amt, Busy<=0, Done<=1, and the block returns to IDLE.
REQ-023: Each step SHALL apply the shift below for the latched mode:
- SHL: Q<={Q[W-2:0],SinR}
- SHR: Q<={SinL,Q[W-1:1]}
- ROL: Q<={Q[W-2:0],Q[W-1]}
- ROR: Q<={Q[0],Q[W-1:1]}
- ASR: Q<={Q[W-1],Q[W-1:1]}
REQ-024: SinL and SinR SHALL be sampled live at each step edge and never latched.
REQ-025: Amt > WIDTH SHALL be legal: rotates wrap, and logical/arithmetic shifts saturate to the fill pattern.
REQ-026: Start, Mode, Amt and I SHALL be ignored while Busy=1.
REQ-027: Hold high in RUN SHALL pause the step counter with Busy held at 1; it SHALL NOT extend or cut the Done pulse.
REQ-028: Hold high on a Start edge SHALL cause the Start to be ignored.
REQ-029: Set asserted in RUN SHALL load all ones into Q, abort to IDLE with Busy=0, and produce no Done.
REQ-030: Done SHALL be high for exactly one cycle per completed operation and never during Rst.

Reset
REQ-031: Rst SHALL, at the next edge, force Q=0, Busy=0, Done=0, the step counter to 0 and the FSM to IDLE, including mid-RUN.
REQ-032: No asynchronous reset or preset path SHALL exist.

Structure
REQ-033: Mode encodings, the FSM state type (IDLE, RUN) and the AW derivation SHALL reside in the shared package shift_pkg.
REQ-034: The FSM and step counter SHALL be a sub-module shift_ctrl that outputs a step enable.
REQ-035: The datapath SHALL be a single WIDTH-bit register with next-state multiplexing.

Verification (WIDTH=8)
REQ-036: Rst for 1 cycle mid-RUN -> Q=00, Busy=0, Done=0 on the next cycle.
REQ-037: LOAD with I=A5 plus Start -> Q=A5 and Done=1 for 1 cycle, Busy never 1.
REQ-038: Q=A5, ROL, Amt=3 -> Busy=1 for 3 cycles, Q=2D, then one Done pulse.
REQ-039: Q=80, ASR, Amt=2 -> Q=E0; Q=A5, SHR, Amt=8, SinL=0 -> Q=00.
REQ-040: Q=A5, SHL, Amt=4, SinR=1, Hold high for 2 cycles mid-run -> Q=5F with Done 2 cycles later than unheld.
REQ-041: Set during RUN -> Q=FF, Busy=0, no Done; Start while Busy with Mode LOAD -> ignored.
